// File: rtl/bram_seq_ctrl.sv
// Staggered run controller for the bram_top array: ramps enables up, runs a fixed window,
// collects pass flags, ramps enables down. Optional macro BRAM_SEQ_FAIL_HALT_EN ends RUN early.
module bram_seq_ctrl #(
    parameter int unsigned NUM        = 10,
    parameter int unsigned STAGGER    = 16,
    parameter int unsigned RUN_CYCLES = 1024
) (
    input  logic           ref_clk_in,
    input  logic           reset,
    input  logic           start_in,
    input  logic           stop_in,
    input  logic [NUM-1:0] pass_in,
    output logic [NUM-1:0] dut_enable_out,
    output logic [NUM-1:0] dut_start_out,
    output logic           busy_out,
    output logic           done_out,
    output logic           pass_out,
    output logic [NUM-1:0] fail_map_out
);

`ifdef BRAM_SEQ_FAIL_HALT_EN
    localparam bit FailHalt = 1'b1;
`else
    localparam bit FailHalt = 1'b0;
`endif

    localparam int unsigned RampCycles = NUM * STAGGER;
    localparam int unsigned MaxCount   = (RampCycles > RUN_CYCLES) ? RampCycles : RUN_CYCLES;
    localparam int unsigned CntW       = $clog2(MaxCount) + 1;
    localparam int unsigned StgW       = $clog2(STAGGER) + 1;

    localparam logic [CntW-1:0] RampLast = CntW'(RampCycles - 1);
    localparam logic [CntW-1:0] RunLast  = CntW'(RUN_CYCLES - 1);
    localparam logic [StgW-1:0] StgLast  = StgW'(STAGGER - 1);

    typedef enum logic [2:0] {StIdle, StRamp, StRun, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [StgW-1:0] stg_q, stg_d;
    logic [NUM-1:0]  en_q, en_d;
    logic [NUM-1:0]  st_q, st_d;
    logic [NUM-1:0]  fail_q, fail_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            completed_q, completed_d;
    logic            enter_drain;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stg_d       = stg_q;
        en_d        = en_q;
        st_d        = st_q;
        fail_d      = fail_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        completed_d = completed_q;
        enter_drain = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_in && !stop_in) begin
                    state_d     = StRamp;
                    cnt_d       = '0;
                    stg_d       = '0;
                    en_d        = NUM'(1);
                    st_d        = NUM'(1);
                    fail_d      = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    completed_d = 1'b0;
                end
            end
            StRamp: begin
                cnt_d = cnt_q + CntW'(1);
                stg_d = stg_q + StgW'(1);
                // Enables form a thermometer code; one more instance joins per stagger slot.
                if (stg_q == StgLast) begin
                    stg_d = '0;
                    en_d  = (en_q << 1) | NUM'(1);
                    st_d  = (st_q << 1) | NUM'(1);
                end
                if (stop_in) begin
                    enter_drain = 1'b1;
                end else if (cnt_q == RampLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                fail_d = fail_q | ~pass_in;
                cnt_d  = cnt_q + CntW'(1);
                if (stop_in || (FailHalt && (fail_q != '0))) begin
                    enter_drain = 1'b1;
                end else if (cnt_q == RunLast) begin
                    completed_d = 1'b1;
                    enter_drain = 1'b1;
                end
            end
            StDrain: begin
                stg_d = stg_q + StgW'(1);
                if (stg_q == StgLast) begin
                    stg_d = '0;
                    if (en_q == '0) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = completed_q && (fail_q == '0);
                    end else begin
                        en_d = en_q >> 1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Entering DRAIN drops every start and the highest enable on the same edge.
        if (enter_drain) begin
            state_d = StDrain;
            cnt_d   = '0;
            stg_d   = '0;
            en_d    = en_q >> 1;
            st_d    = '0;
        end
    end

    always_ff @(posedge ref_clk_in) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            stg_q       <= '0;
            en_q        <= '0;
            st_q        <= '0;
            fail_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            completed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stg_q       <= stg_d;
            en_q        <= en_d;
            st_q        <= st_d;
            fail_q      <= fail_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            completed_q <= completed_d;
        end
    end

    assign dut_enable_out = en_q;
    assign dut_start_out  = st_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign pass_out       = pass_q;
    assign fail_map_out   = fail_q;

endmodule

// File: tb/tb_bram_seq_ctrl.sv
// Scoreboard bench for bram_seq_ctrl (NUM=4, STAGGER=2, RUN_CYCLES=8): stimulus pushes the
// expected outputs for each cycle, a negedge monitor pops and compares.
module tb_bram_seq_ctrl;
    localparam int unsigned NUM        = 4;
    localparam int unsigned STAGGER    = 2;
    localparam int unsigned RUN_CYCLES = 8;

    logic           clk      = 1'b0;
    logic           reset    = 1'b0;
    logic           start_in = 1'b0;
    logic           stop_in  = 1'b0;
    logic [NUM-1:0] pass_in  = 4'hF;
    logic [NUM-1:0] dut_enable_out;
    logic [NUM-1:0] dut_start_out;
    logic           busy_out;
    logic           done_out;
    logic           pass_out;
    logic [NUM-1:0] fail_map_out;

    bram_seq_ctrl #(
        .NUM       (NUM),
        .STAGGER   (STAGGER),
        .RUN_CYCLES(RUN_CYCLES)
    ) dut (
        .ref_clk_in    (clk),
        .reset         (reset),
        .start_in      (start_in),
        .stop_in       (stop_in),
        .pass_in       (pass_in),
        .dut_enable_out(dut_enable_out),
        .dut_start_out (dut_start_out),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .pass_out      (pass_out),
        .fail_map_out  (fail_map_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    name;
        int       n;
        logic [3:0] en;
        logic [3:0] st;
        logic [3:0] fm;
        logic     busy;
        logic     done;
        logic     pass;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef BRAM_SEQ_FAIL_HALT_EN
    localparam int FailDrainAt = 14;
`else
    localparam int FailDrainAt = 17;
`endif

    // Expected outputs at t0+n: d = first DRAIN cycle, m = instances enabled on DRAIN entry.
    function automatic exp_t model(input string name, input int n, input int d, input int m,
                                   input bit pass_ok, input int fm_t, input logic [3:0] fm_v);
        exp_t e;
        int   k;
        e.name = name;
        e.n    = n;
        e.busy = (n < d + int'(STAGGER) * m);
        e.done = !e.busy;
        if (n < d) begin
            k = (n - 1) / int'(STAGGER) + 1;
            if (k > int'(NUM)) k = int'(NUM);
            e.en = 4'((1 << k) - 1);
            e.st = e.en;
        end else begin
            k = m - 1 - (n - d) / int'(STAGGER);
            if (k < 0) k = 0;
            e.en = 4'((1 << k) - 1);
            e.st = 4'h0;
        end
        e.pass = e.done && pass_ok;
        e.fm   = (fm_t > 0 && n >= fm_t) ? fm_v : 4'h0;
        return e;
    endfunction

    function automatic exp_t zeros(input string name, input int n);
        exp_t e;
        e.name = name;
        e.n    = n;
        e.en   = 4'h0;
        e.st   = 4'h0;
        e.fm   = 4'h0;
        e.busy = 1'b0;
        e.done = 1'b0;
        e.pass = 1'b0;
        return e;
    endfunction

    task automatic step(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Inputs set at index j are sampled at edge t0+j; expectation is for t0+j+1.
    task automatic run_scn(input string name, input int nmax, input int d, input int m,
                           input bit pass_ok, input int fm_t, input logic [3:0] fm_v,
                           input int stop_at, input int fail_at, input int start2_at,
                           input bit pass_low);
        for (int j = 0; j < nmax; j++) begin
            start_in = (j == 0) || (j == start2_at);
            stop_in  = (j == stop_at);
            pass_in  = pass_low ? 4'h0 : ((j == fail_at) ? 4'hB : 4'hF);
            step(model(name, j + 1, d, m, pass_ok, fm_t, fm_v));
        end
        start_in = 1'b0;
        stop_in  = 1'b0;
        pass_in  = 4'hF;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            n_cmp++;
            if ({dut_enable_out, dut_start_out, fail_map_out, busy_out, done_out, pass_out} !==
                {mon_e.en, mon_e.st, mon_e.fm, mon_e.busy, mon_e.done, mon_e.pass}) begin
                n_bad++;
                $display("FAIL %s t0+%0d: got en=%h st=%h fm=%h busy=%b done=%b pass=%b, want en=%h st=%h fm=%h busy=%b done=%b pass=%b",
                         mon_e.name, mon_e.n, dut_enable_out, dut_start_out, fail_map_out,
                         busy_out, done_out, pass_out, mon_e.en, mon_e.st, mon_e.fm,
                         mon_e.busy, mon_e.done, mon_e.pass);
            end
        end
    end

    initial begin
        reset = 1'b0;
        step(zeros("reset", 0));
        step(zeros("reset", 0));
        reset = 1'b1;
        step(zeros("idle", 0));

        run_scn("clean", 27, 17, 4, 1'b1, -1, 4'h0, -1, -1, -1, 1'b0);
        run_scn("fail_pulse", 27, FailDrainAt, 4, 1'b0, 13, 4'h4, -1, 12, -1, 1'b0);
        // fail_map must clear on the accepting edge; pass_in low outside RUN is ignored.
        run_scn("stop_ramp", 11, 5, 2, 1'b0, -1, 4'h0, 4, -1, -1, 1'b1);

        start_in = 1'b1;
        stop_in  = 1'b1;
        step(model("done_start_stop", 30, 5, 2, 1'b0, -1, 4'h0));
        step(model("done_start_stop", 31, 5, 2, 1'b0, -1, 4'h0));
        start_in = 1'b0;
        stop_in  = 1'b0;

        for (int j = 0; j < 10; j++) begin
            start_in = (j == 0);
            step(model("pre_reset", j + 1, 17, 4, 1'b1, -1, 4'h0));
        end
        start_in = 1'b0;
        reset    = 1'b0;
        step(zeros("mid_reset", 11));
        reset = 1'b1;
        step(zeros("post_reset", 12));

        start_in = 1'b1;
        stop_in  = 1'b1;
        for (int j = 0; j < 3; j++) step(zeros("idle_start_stop", j));
        start_in = 1'b0;
        stop_in  = 1'b0;

        run_scn("clean_again", 27, 17, 4, 1'b1, -1, 4'h0, -1, -1, 11, 1'b0);

        stop_in = 1'b1;
        step(model("done_stop", 40, 17, 4, 1'b1, -1, 4'h0));
        step(model("done_stop", 41, 17, 4, 1'b1, -1, 4'h0));
        stop_in = 1'b0;

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_queue: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
